// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx
//   Reads a raster-ordered frame out of a synchronous frame memory and
//   streams it out over a valid/ready interface. Each pixel carries
//   start/end of frame/line markers. A 2-entry output FIFO decouples the
//   one-cycle memory latency from downstream backpressure.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   start             begin a frame (only looked at while idle)
//   abort             drop the current frame immediately
//   mem_rd_en         frame-memory read request
//   mem_addr          frame-memory read address (y*IMAGE_WIDTH + x)
//   mem_rd_data       read data, valid one cycle after mem_rd_en
//   pixel_out         pixel at the FIFO head
//   pixel_valid       pixel_out and markers are valid
//   pixel_ready       downstream accepts the head pixel
//   sof, sol, eol, eof  frame/line markers of the head pixel
//   busy              a frame is in progress
//   done              one-cycle pulse when a frame completes normally
module pixel_stream_tx #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int H_BLANK      = 4,
  localparam int ADDR_W      = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        pixel_out,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              sof,
  output logic              sol,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int X_W  = $clog2(IMAGE_WIDTH);
  localparam int Y_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int HB_W = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

  localparam logic [X_W-1:0]  X_LAST  = X_W'(IMAGE_WIDTH - 1);
  localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(IMAGE_HEIGHT - 1);
  localparam logic [HB_W-1:0] HB_LOAD = HB_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [HB_W-1:0]     hb_q, hb_d;
  logic                pend_q, pend_d;
  logic [3:0]          tag_q, tag_d;
  // FIFO entries are {pixel[7:0], sof, sol, eol, eof}; entry 0 is the head.
  logic [11:0]         fifo0_q, fifo0_d;
  logic [11:0]         fifo1_q, fifo1_d;
  logic [1:0]          cnt_q, cnt_d;

  logic                pop;
  logic                push;
  logic                room_ok;
  logic                rd_issue;
  logic                is_eol;
  logic                is_last;
  logic                done_c;
  logic [11:0]         new_entry;

  // Occupancy bookkeeping: a read may be issued only if the entries held
  // after this cycle (FIFO + arriving data - departing head) leave room
  // for the data that the new read will return next cycle.
  always_comb begin
    pop       = (cnt_q != 2'd0) && pixel_ready;
    push      = pend_q && !abort;
    room_ok   = ({1'b0, cnt_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop});
    rd_issue  = (state_q == ACTIVE) && !abort && room_ok;
    is_eol    = (x_q == X_LAST);
    is_last   = is_eol && (y_q == Y_LAST);
    new_entry = {mem_rd_data, tag_q};
  end

  // Output FIFO update; abort flushes it and drops any returning read.
  always_comb begin
    fifo0_d = fifo0_q;
    fifo1_d = fifo1_q;
    cnt_d   = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) fifo0_d = new_entry;
        else               fifo1_d = new_entry;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        fifo0_d = fifo1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          fifo0_d = new_entry;
        end else begin
          fifo0_d = fifo1_q;
          fifo1_d = new_entry;
        end
      end
      default: ;
    endcase
    if (abort) cnt_d = 2'd0;
  end

  // Frame sequencing: raster counters advance on every issued read, and
  // the tag recorded at issue travels with the data into the FIFO.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    hb_d    = hb_q;
    pend_d  = rd_issue;
    tag_d   = tag_q;
    done_c  = 1'b0;

    if (rd_issue) begin
      tag_d  = {(x_q == '0) && (y_q == '0), (x_q == '0), is_eol, is_last};
      addr_d = addr_q + ADDR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (rd_issue) begin
          if (is_last) begin
            state_d = DRAIN;
          end else if (is_eol) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
            if (H_BLANK > 0) begin
              state_d = HBLANK;
              hb_d    = HB_LOAD;
            end
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      HBLANK: begin
        if (hb_q == '0) state_d = ACTIVE;
        else            hb_d    = hb_q - HB_W'(1);
      end
      DRAIN: begin
        if ((cnt_q == 2'd0) && !pend_q) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Returning to idle always leaves the raster position at the origin.
    if (abort || (state_d == IDLE)) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
      hb_d    = '0;
      done_c  = done_c && !abort;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      hb_q    <= '0;
      pend_q  <= 1'b0;
      tag_q   <= '0;
      fifo0_q <= '0;
      fifo1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      hb_q    <= hb_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
      fifo0_q <= fifo0_d;
      fifo1_q <= fifo1_d;
      cnt_q   <= cnt_d;
    end
  end

  // Head-of-FIFO outputs are forced to zero when nothing is valid.
  always_comb begin
    pixel_valid = (cnt_q != 2'd0);
    pixel_out   = pixel_valid ? fifo0_q[11:4] : 8'd0;
    sof         = pixel_valid && fifo0_q[3];
    sol         = pixel_valid && fifo0_q[2];
    eol         = pixel_valid && fifo0_q[1];
    eof         = pixel_valid && fifo0_q[0];
    mem_rd_en   = rd_issue;
    mem_addr    = addr_q;
    busy        = (state_q != IDLE);
    done        = done_c;
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx
//   Drives three instances of pixel_stream_tx (W4xH2 no blanking, W4xH2
//   with 3 blanking cycles, W8xH1 with 2 blanking cycles) against a
//   behavioural frame memory. The expected stream is the memory contents in
//   raster order with markers derived from each pixel's index.
module tb_pixel_stream_tx;

  localparam int NPIX = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_s  [3];
  logic       abort_s  [3];
  logic       ready_s  [3];
  logic       rd_en_s  [3];
  logic [2:0] addr_s   [3];
  logic [7:0] rdata_s  [3];
  logic [7:0] pix_s    [3];
  logic       valid_s  [3];
  logic       sof_s    [3];
  logic       sol_s    [3];
  logic       eol_s    [3];
  logic       eof_s    [3];
  logic       busy_s   [3];
  logic       done_s   [3];

  int         wid [3] = '{4, 4, 8};
  int         hgt [3] = '{2, 2, 1};
  logic [7:0] mem [3][NPIX];

  int checks   = 0;
  int failures = 0;

  int         xf_cyc  [$];
  logic [7:0] xf_pix  [$];
  logic [3:0] xf_mark [$];
  int         rd_cyc  [$];
  int         rd_addr [$];
  int         done_cnt;
  int         done_cyc;
  int         max_out;
  int         stab_err;
  int         abort_cyc;
  logic       post_bad;

  always #5 clk = ~clk;

  pixel_stream_tx #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .H_BLANK(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .abort(abort_s[0]),
    .mem_rd_en(rd_en_s[0]), .mem_addr(addr_s[0]), .mem_rd_data(rdata_s[0]),
    .pixel_out(pix_s[0]), .pixel_valid(valid_s[0]), .pixel_ready(ready_s[0]),
    .sof(sof_s[0]), .sol(sol_s[0]), .eol(eol_s[0]), .eof(eof_s[0]),
    .busy(busy_s[0]), .done(done_s[0]));

  pixel_stream_tx #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .H_BLANK(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .abort(abort_s[1]),
    .mem_rd_en(rd_en_s[1]), .mem_addr(addr_s[1]), .mem_rd_data(rdata_s[1]),
    .pixel_out(pix_s[1]), .pixel_valid(valid_s[1]), .pixel_ready(ready_s[1]),
    .sof(sof_s[1]), .sol(sol_s[1]), .eol(eol_s[1]), .eof(eof_s[1]),
    .busy(busy_s[1]), .done(done_s[1]));

  pixel_stream_tx #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(1), .H_BLANK(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_s[2]), .abort(abort_s[2]),
    .mem_rd_en(rd_en_s[2]), .mem_addr(addr_s[2]), .mem_rd_data(rdata_s[2]),
    .pixel_out(pix_s[2]), .pixel_valid(valid_s[2]), .pixel_ready(ready_s[2]),
    .sof(sof_s[2]), .sol(sol_s[2]), .eol(eol_s[2]), .eof(eof_s[2]),
    .busy(busy_s[2]), .done(done_s[2]));

  // Synchronous frame memory: data one cycle after the read request.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++)
      rdata_s[d] <= rd_en_s[d] ? mem[d][addr_s[d]] : 8'hA5;
  end

  // Expected markers {sof, sol, eol, eof} for the k-th pixel of a frame.
  function automatic logic [3:0] exp_mark(input int d, input int k);
    int w = wid[d];
    int h = hgt[d];
    return {k == 0, (k % w) == 0, (k % w) == w - 1, k == w * h - 1};
  endfunction

  task automatic fill_mem(input int d, input bit ramp);
    for (int a = 0; a < NPIX; a++)
      mem[d][a] = ramp ? 8'(a) : 8'($urandom);
  endtask

  function automatic logic [18:0] out_vec(input int d);
    return {rd_en_s[d], addr_s[d], pix_s[d], valid_s[d], sof_s[d], sol_s[d],
            eol_s[d], eof_s[d], busy_s[d], done_s[d]};
  endfunction

  // Runs one frame on instance d and records what was observed. Cycle 0 is
  // the cycle in which start is high. mode: 0 ready=1, 1 random ready,
  // 2 ready low for the first stall_n cycles.
  task automatic capture(input int d, input int mode, input int stall_n,
                         input int abort_at, input int restart_cyc,
                         input int max_cyc);
    int          xfers;
    int          issued;
    logic        stalled;
    logic [11:0] held;
    logic [11:0] now_v;
    xf_cyc.delete(); xf_pix.delete(); xf_mark.delete();
    rd_cyc.delete(); rd_addr.delete();
    done_cnt = 0; done_cyc = -1; max_out = 0; stab_err = 0;
    abort_cyc = -1; post_bad = 1'b0;
    xfers = 0; issued = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      start_s[d] = (cyc == 0) || (cyc == restart_cyc);
      case (mode)
        1:       ready_s[d] = 1'($urandom_range(0, 1));
        2:       ready_s[d] = (cyc >= stall_n);
        default: ready_s[d] = 1'b1;
      endcase
      abort_s[d] = (abort_at >= 0) && (xfers == abort_at) && (abort_cyc < 0);
      if (abort_s[d]) abort_cyc = cyc;
      #1;
      now_v = {pix_s[d], sof_s[d], sol_s[d], eol_s[d], eof_s[d]};
      if (stalled && (!valid_s[d] || now_v !== held)) stab_err++;
      if (rd_en_s[d]) begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(int'(addr_s[d]));
        issued++;
      end
      if (done_s[d]) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (valid_s[d] && ready_s[d]) begin
        xf_cyc.push_back(cyc);
        xf_pix.push_back(pix_s[d]);
        xf_mark.push_back(now_v[3:0]);
        xfers++;
      end
      if (issued - xfers > max_out) max_out = issued - xfers;
      if (abort_cyc >= 0 && cyc > abort_cyc &&
          (valid_s[d] || busy_s[d] || rd_en_s[d] || done_s[d]))
        post_bad = 1'b1;
      stalled = valid_s[d] && !ready_s[d];
      held    = now_v;
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
      if (abort_cyc >= 0 && cyc >= abort_cyc + 3) break;
    end
    @(negedge clk);
    start_s[d] = 1'b0;
    abort_s[d] = 1'b0;
    ready_s[d] = 1'b1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (out_vec(d) !== 19'd0) begin
        failures++;
        $display("[TB] FAIL reset_outputs[%0d]: got %h expected 0", d, out_vec(d));
      end
    end
  endtask

  task automatic test_raster_timing();
    fill_mem(0, 1'b1);
    capture(0, 0, 0, -1, -1, 60);
    checks++;
    if (xf_cyc.size() != NPIX) begin
      failures++;
      $display("[TB] FAIL raster_count: got %0d expected %0d", xf_cyc.size(), NPIX);
    end
    for (int k = 0; k < xf_cyc.size(); k++) begin
      checks++;
      if (xf_cyc[k] != k + 3) begin
        failures++;
        $display("[TB] FAIL raster_cycle[%0d]: got %0d expected %0d", k, xf_cyc[k], k + 3);
      end
      checks++;
      if (xf_pix[k] !== mem[0][k] || xf_mark[k] !== exp_mark(0, k)) begin
        failures++;
        $display("[TB] FAIL raster_data[%0d]: got %h/%b expected %h/%b",
                 k, xf_pix[k], xf_mark[k], mem[0][k], exp_mark(0, k));
      end
    end
    checks++;
    if (rd_cyc[0] != 1) begin
      failures++;
      $display("[TB] FAIL raster_first_read: got %0d expected 1", rd_cyc[0]);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 11) begin
      failures++;
      $display("[TB] FAIL raster_done: got %0d pulses at %0d expected 1 at 11", done_cnt, done_cyc);
    end
  endtask

  task automatic test_hblank();
    int gap;
    fill_mem(1, 1'b0);
    capture(1, 0, 0, -1, -1, 80);
    checks++;
    if (rd_cyc.size() != NPIX || xf_cyc.size() != NPIX) begin
      failures++;
      $display("[TB] FAIL hblank_counts: got %0d reads %0d pixels expected 8 and 8",
               rd_cyc.size(), xf_cyc.size());
    end
    for (int k = 0; k < rd_cyc.size(); k++) begin
      gap = (k >= 4) ? 3 : 0;
      checks++;
      if (rd_cyc[k] != k + 1 + gap || rd_addr[k] != k) begin
        failures++;
        $display("[TB] FAIL hblank_read[%0d]: got addr %0d at %0d expected addr %0d at %0d",
                 k, rd_addr[k], rd_cyc[k], k, k + 1 + gap);
      end
    end
    for (int k = 0; k < xf_cyc.size(); k++) begin
      gap = (k >= 4) ? 3 : 0;
      checks++;
      if (xf_cyc[k] != k + 3 + gap || xf_pix[k] !== mem[1][k] || xf_mark[k] !== exp_mark(1, k)) begin
        failures++;
        $display("[TB] FAIL hblank_pixel[%0d]: got %h/%b at %0d expected %h/%b at %0d",
                 k, xf_pix[k], xf_mark[k], xf_cyc[k], mem[1][k], exp_mark(1, k), k + 3 + gap);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("[TB] FAIL hblank_done: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    for (int rep = 0; rep < 6; rep++) begin
      int d = rep % 3;
      fill_mem(d, 1'b0);
      capture(d, 1, 0, -1, 6, 400);
      checks++;
      if (xf_pix.size() != NPIX || rd_addr.size() != NPIX) begin
        failures++;
        $display("[TB] FAIL bp_counts[%0d]: got %0d pixels %0d reads expected 8 and 8",
                 rep, xf_pix.size(), rd_addr.size());
      end
      for (int k = 0; k < xf_pix.size(); k++) begin
        checks++;
        if (xf_pix[k] !== mem[d][k] || xf_mark[k] !== exp_mark(d, k)) begin
          failures++;
          $display("[TB] FAIL bp_pixel[%0d][%0d]: got %h/%b expected %h/%b",
                   rep, k, xf_pix[k], xf_mark[k], mem[d][k], exp_mark(d, k));
        end
      end
      for (int k = 0; k < rd_addr.size(); k++) begin
        checks++;
        if (rd_addr[k] != k) begin
          failures++;
          $display("[TB] FAIL bp_addr[%0d][%0d]: got %0d expected %0d", rep, k, rd_addr[k], k);
        end
      end
      checks++;
      if (stab_err != 0 || max_out > 2 || done_cnt != 1) begin
        failures++;
        $display("[TB] FAIL bp_flow[%0d]: got unstable=%0d outstanding=%0d done=%0d expected 0, <=2, 1",
                 rep, stab_err, max_out, done_cnt);
      end
    end
  endtask

  task automatic test_stall();
    int early;
    fill_mem(0, 1'b1);
    capture(0, 2, 20, -1, -1, 100);
    early = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] < 20) early++;
    checks++;
    if (early != 2) begin
      failures++;
      $display("[TB] FAIL stall_reads: got %0d expected 2", early);
    end
    checks++;
    if (stab_err != 0 || xf_pix.size() != NPIX) begin
      failures++;
      $display("[TB] FAIL stall_hold: got unstable=%0d pixels=%0d expected 0 and 8",
               stab_err, xf_pix.size());
    end
    for (int k = 0; k < xf_cyc.size(); k++) begin
      checks++;
      if (xf_cyc[k] != 20 + k || xf_pix[k] !== mem[0][k]) begin
        failures++;
        $display("[TB] FAIL stall_resume[%0d]: got %h at %0d expected %h at %0d",
                 k, xf_pix[k], xf_cyc[k], mem[0][k], 20 + k);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("[TB] FAIL stall_done: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_abort();
    logic bad;
    fill_mem(0, 1'b1);
    capture(0, 0, 0, 5, -1, 60);
    checks++;
    if (abort_cyc != 8 || post_bad !== 1'b0 || done_cnt != 0) begin
      failures++;
      $display("[TB] FAIL abort_effect: got cyc=%0d post_active=%0b done=%0d expected 8, 0, 0",
               abort_cyc, post_bad, done_cnt);
    end
    @(negedge clk);
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (busy_s[0] || rd_en_s[0] || valid_s[0]) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_beats_start: got busy activity %0b expected 0", bad);
    end
    capture(0, 0, 0, -1, -1, 60);
    checks++;
    if (xf_pix.size() != NPIX || xf_pix[0] !== 8'd0 || xf_mark[0] !== 4'b1100 || xf_cyc[0] != 3) begin
      failures++;
      $display("[TB] FAIL abort_restart: got n=%0d pix=%h mark=%b cyc=%0d expected 8, 00, 1100, 3",
               xf_pix.size(), xf_pix[0], xf_mark[0], xf_cyc[0]);
    end
  endtask

  task automatic test_reset_midframe();
    logic bad;
    fill_mem(0, 1'b0);
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    start_s[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_vec(0) !== 19'd0) begin
        failures++;
        $display("[TB] FAIL midreset_outputs[%0d]: got %h expected 0", i, out_vec(0));
      end
    end
    @(negedge clk);
    start_s[0] = 1'b0;
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_vec(0) !== 19'd0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_quiet: got activity %0b expected 0", bad);
    end
    capture(0, 1, 0, -1, -1, 300);
    checks++;
    if (xf_pix.size() != NPIX || xf_pix[0] !== mem[0][0] || xf_pix[7] !== mem[0][7] || done_cnt != 1) begin
      failures++;
      $display("[TB] FAIL midreset_recover: got n=%0d first=%h last=%h done=%0d expected 8, %h, %h, 1",
               xf_pix.size(), xf_pix[0], xf_pix[7], done_cnt, mem[0][0], mem[0][7]);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b1;
      abort_s[d] = 1'b0;
      ready_s[d] = 1'b1;
      fill_mem(d, 1'b1);
    end
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    test_raster_timing();
    test_hblank();
    test_backpressure();
    test_stall();
    test_abort();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
